// File: rtl/seg7_count_ctrl_if.sv
// seg7_count_ctrl_if: button/counter/display signal bundle for the seg7 count controller
interface seg7_count_ctrl_if;
  logic        start_stop;
  logic        clear;
  logic [15:0] bcd_in;
  logic        count_en;
  logic        cnt_clr;
  logic [1:0]  state;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  modport master (
    output start_stop, clear, bcd_in,
    input  count_en, cnt_clr, state, an, seg, dp_n
  );
  modport slave (
    input  start_stop, clear, bcd_in,
    output count_en, cnt_clr, state, an, seg, dp_n
  );
endinterface

// File: rtl/seg7_count_ctrl.sv
// seg7_count_ctrl: run/pause/clear FSM, count prescaler and 4-digit multiplexed 7-segment driver
module seg7_count_ctrl #(
  parameter int TICK_DIV = 10_000_000,
  parameter int SCAN_DIV = 100_000,
  parameter bit SATURATE = 1'b1
) (
  input logic clk,
  input logic rst_n,
  seg7_count_ctrl_if.slave bus
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, HALT = 2'b11} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0] idx_q, idx_d;
  logic count_en_q, count_en_d;
  logic cnt_clr_q, cnt_clr_d;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic dp_n_q, dp_n_d;
  logic tick, at_max, scan_wrap, blank;
  logic [3:0] digit;
  logic [6:0] glyph;
  assign tick = (state_q == RUN) && (tick_cnt_q == TICK_LAST);
  assign at_max = bus.bcd_in == 16'h9999;
  assign scan_wrap = scan_cnt_q == SCAN_LAST;
  assign digit = bus.bcd_in[{idx_q, 2'b00} +: 4];
  assign blank = (idx_q != 2'd0) && ((bus.bcd_in >> {idx_q, 2'b00}) == 16'h0);
  // FSM transitions and prescaler; clear overrides everything, including a coincident tick
  always_comb begin
    state_d = state_q;
    tick_cnt_d = tick_cnt_q;
    count_en_d = 1'b0;
    cnt_clr_d = bus.clear;
    if (state_q == RUN) tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    case (state_q)
      IDLE: if (bus.start_stop) state_d = RUN;
      RUN: begin
        if (tick && SATURATE && at_max) state_d = HALT;
        else begin
          count_en_d = tick;
          if (bus.start_stop) state_d = PAUSE;
        end
      end
      PAUSE: if (bus.start_stop) state_d = RUN;
      default: ;
    endcase
    if (bus.clear) begin
      state_d = IDLE;
      tick_cnt_d = '0;
      count_en_d = 1'b0;
    end
  end
  // BCD digit to active-low {g,f,e,d,c,b,a}; anything above 9 renders as a dash
  always_comb begin
    case (digit)
      4'd0: glyph = 7'b1000000;
      4'd1: glyph = 7'b1111001;
      4'd2: glyph = 7'b0100100;
      4'd3: glyph = 7'b0110000;
      4'd4: glyph = 7'b0011001;
      4'd5: glyph = 7'b0010010;
      4'd6: glyph = 7'b0000010;
      4'd7: glyph = 7'b1111000;
      4'd8: glyph = 7'b0000000;
      4'd9: glyph = 7'b0010000;
      default: glyph = 7'b0111111;
    endcase
  end
  // Free-running digit scanner and the display word for the digit currently selected
  always_comb begin
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SW'(1);
    idx_d = scan_wrap ? idx_q + 2'd1 : idx_q;
    an_d = ~(4'b0001 << idx_q);
    seg_d = blank ? 7'h7F : glyph;
    dp_n_d = !((state_q == HALT) || (state_q == PAUSE && idx_q == 2'd0));
  end
  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_cnt_q <= '0;
      scan_cnt_q <= '0;
      idx_q <= 2'd0;
      count_en_q <= 1'b0;
      cnt_clr_q <= 1'b0;
      an_q <= 4'b1111;
      seg_q <= 7'h7F;
      dp_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_cnt_q <= tick_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q <= idx_d;
      count_en_q <= count_en_d;
      cnt_clr_q <= cnt_clr_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dp_n_q <= dp_n_d;
    end
  end
  assign bus.count_en = count_en_q;
  assign bus.cnt_clr = cnt_clr_q;
  assign bus.state = state_q;
  assign bus.an = an_q;
  assign bus.seg = seg_q;
  assign bus.dp_n = dp_n_q;
endmodule

// File: tb/tb_seg7_count_ctrl.sv
// tb_seg7_count_ctrl: scoreboard bench for the seg7 count controller (TICK_DIV=4, SCAN_DIV=2)
module tb_seg7_count_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  seg7_count_ctrl_if bus();
  seg7_count_ctrl #(.TICK_DIV(4), .SCAN_DIV(2), .SATURATE(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    int cyc;
    bit [5:0] m;
    logic ce;
    logic clr;
    logic [1:0] st;
    logic [3:0] an;
    logic [6:0] seg;
    logic dp;
    bit [63:0] nm;
  } exp_t;
  localparam bit [5:0] M_CE = 6'd1, M_CLR = 6'd2, M_ST = 6'd4, M_AN = 6'd8, M_SEG = 6'd16, M_DP = 6'd32;
  exp_t q[$];
  int cyc = 0;
  int rc = 0;
  int checks = 0;
  int failures = 0;
  bit done = 1'b0;
  logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seg_0405 [4] = '{7'h12, 7'h40, 7'h19, 7'h7F};
  logic [6:0] seg_00a0 [4] = '{7'h40, 7'h3F, 7'h7F, 7'h7F};
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void push(int d, bit [5:0] m, logic ce, logic clr, logic [1:0] st,
                               logic [3:0] an, logic [6:0] seg, logic dp, bit [63:0] nm);
    exp_t e;
    int p;
    e.cyc = cyc + d; e.m = m; e.ce = ce; e.clr = clr; e.st = st;
    e.an = an; e.seg = seg; e.dp = dp; e.nm = nm;
    p = q.size();
    while (p > 0 && q[p-1].cyc > e.cyc) p--;
    q.insert(p, e);
  endfunction
  function automatic void push_ce(int d, logic v, bit [63:0] nm);
    push(d, M_CE, v, 1'b0, 2'b00, 4'h0, 7'h0, 1'b0, nm);
  endfunction
  function automatic void push_st(int d, logic [1:0] st, bit [63:0] nm);
    push(d, M_ST, 1'b0, 1'b0, st, 4'h0, 7'h0, 1'b0, nm);
  endfunction
  function automatic void push_clr(int d, logic v, bit [63:0] nm);
    push(d, M_CLR, 1'b0, v, 2'b00, 4'h0, 7'h0, 1'b0, nm);
  endfunction
  function automatic int didx(int d);
    return ((cyc + d - rc - 1) / 2) % 4;
  endfunction
  task automatic chk(input bit [63:0] nm, input string f, input logic [15:0] got, input logic [15:0] ex);
    checks++;
    if (got !== ex) begin
      failures++;
      $display("FAIL %0s.%0s cyc=%0d got=%h exp=%h", nm, f, cyc, got, ex);
    end
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) chk(e.nm, "missed", 16'(e.cyc), 16'(cyc));
      else begin
        if (e.m[0]) chk(e.nm, "count_en", 16'(bus.count_en), 16'(e.ce));
        if (e.m[1]) chk(e.nm, "cnt_clr", 16'(bus.cnt_clr), 16'(e.clr));
        if (e.m[2]) chk(e.nm, "state", 16'(bus.state), 16'(e.st));
        if (e.m[3]) chk(e.nm, "an", 16'(bus.an), 16'(e.an));
        if (e.m[4]) chk(e.nm, "seg", 16'(bus.seg), 16'(e.seg));
        if (e.m[5]) chk(e.nm, "dp_n", 16'(bus.dp_n), 16'(e.dp));
      end
    end
    if (done || cyc > 3000) begin
      if (!done) chk("watchdog", "timeout", 16'(cyc), 16'd0);
      chk("end", "queue_left", 16'(q.size()), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic steps(input int n);
    repeat (n) step();
  endtask
  task automatic pulse(input logic ss, input logic cl);
    bus.start_stop = ss;
    bus.clear = cl;
    step();
    bus.start_stop = 1'b0;
    bus.clear = 1'b0;
  endtask
  initial begin
    bus.start_stop = 1'b0;
    bus.clear = 1'b0;
    bus.bcd_in = 16'h0000;
    steps(2);
    push(0, 6'h3F, 1'b0, 1'b0, 2'b00, 4'hF, 7'h7F, 1'b1, "reset");
    rst_n = 1'b1;
    rc = cyc;
    steps(2);
    push(0, M_CE | M_CLR | M_ST, 1'b0, 1'b0, 2'b00, 4'h0, 7'h0, 1'b0, "idle");
    pulse(1'b1, 1'b0);
    push_st(0, 2'b01, "t1_run");
    for (int d = 0; d <= 12; d++) push_ce(d, d > 0 && d % 4 == 0, "t1_ce");
    steps(13);
    pulse(1'b1, 1'b0);
    push_st(0, 2'b10, "t2_pause");
    for (int d = 0; d <= 9; d++) push_ce(d, 1'b0, "t2_ce");
    for (int d = 1; d <= 9; d++)
      push(d, M_AN | M_DP, 1'b0, 1'b0, 2'b00, an_tab[didx(d)], 7'h0, didx(d) != 0, "t2_dp");
    steps(9);
    pulse(1'b1, 1'b0);
    push_st(0, 2'b01, "t2_resume");
    for (int d = 0; d <= 3; d++) push_ce(d, d == 2, "t2_ce_res");
    steps(3);
    pulse(1'b1, 1'b1);
    push(0, M_CE | M_CLR | M_ST, 1'b0, 1'b1, 2'b00, 4'h0, 7'h0, 1'b0, "t3_clear");
    push_clr(1, 1'b0, "t3_clr_1c");
    pulse(1'b1, 1'b0);
    push_st(0, 2'b01, "t3_rerun");
    for (int d = 0; d <= 8; d++) push_ce(d, d == 4 || d == 8, "t3_ce");
    steps(7);
    pulse(1'b1, 1'b0);
    push_st(0, 2'b10, "t3_tickss");
    pulse(1'b1, 1'b0);
    push_st(0, 2'b01, "t3_run2");
    for (int d = 0; d <= 5; d++) push_ce(d, 1'b0, "t3_tickcl");
    steps(3);
    pulse(1'b0, 1'b1);
    push(0, M_CLR | M_ST, 1'b0, 1'b1, 2'b00, 4'h0, 7'h0, 1'b0, "t3_clr2");
    bus.bcd_in = 16'h9999;
    pulse(1'b1, 1'b0);
    push_st(0, 2'b01, "t4_run");
    for (int d = 0; d <= 8; d++) push_ce(d, 1'b0, "t4_ce");
    push_st(3, 2'b01, "t4_pre");
    push_st(4, 2'b11, "t4_halt");
    for (int d = 5; d <= 10; d++)
      push(d, M_AN | M_DP, 1'b0, 1'b0, 2'b00, an_tab[didx(d)], 7'h0, 1'b0, "t4_dp");
    steps(5);
    pulse(1'b1, 1'b0);
    for (int d = 0; d <= 2; d++) push_st(d, 2'b11, "t4_ssign");
    steps(4);
    pulse(1'b0, 1'b1);
    push(0, M_CLR | M_ST, 1'b0, 1'b1, 2'b00, 4'h0, 7'h0, 1'b0, "t4_clear");
    push(1, M_DP, 1'b0, 1'b0, 2'b00, 4'h0, 7'h0, 1'b1, "t4_dpoff");
    bus.bcd_in = 16'h0405;
    for (int d = 1; d <= 8; d++)
      push(d, M_AN | M_SEG | M_DP, 1'b0, 1'b0, 2'b00, an_tab[didx(d)], seg_0405[didx(d)], 1'b1, "t5_0405");
    steps(8);
    bus.bcd_in = 16'h00A0;
    for (int d = 1; d <= 8; d++)
      push(d, M_AN | M_SEG | M_DP, 1'b0, 1'b0, 2'b00, an_tab[didx(d)], seg_00a0[didx(d)], 1'b1, "t5_00a0");
    steps(8);
    pulse(1'b1, 1'b0);
    steps(2);
    #2;
    rst_n = 1'b0;
    push(0, 6'h3F, 1'b0, 1'b0, 2'b00, 4'hF, 7'h7F, 1'b1, "t6_async");
    steps(2);
    rst_n = 1'b1;
    rc = cyc;
    for (int d = 1; d <= 3; d++)
      push(d, M_CE | M_ST | M_AN | M_SEG, 1'b0, 1'b0, 2'b00, an_tab[didx(d)], seg_00a0[didx(d)], 1'b0, "t6_after");
    steps(5);
    done = 1'b1;
  end
endmodule
